mux21: RTL and testbench

MUX21 -- requirements
Module: mux21

---
 rtl/mux21_pkg.sv | 11 +
 rtl/mux21_bit.sv | 24 ++
 rtl/mux21.sv | 60 ++++++
 tb/tb_mux21.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mux21_pkg.sv
// Shared constants for the mux21 slice: default widths and the saturation fill
// value used to build the select-transition counter limit.
package mux21_pkg;

  localparam int WIDTH_DEF = 1;
  localparam int CNT_W_DEF = 8;

  // The counter stops at all-ones; the limit is this bit replicated CNT_W times.
  localparam bit SAT_FILL = 1'b1;

endpackage

// File: rtl/mux21_bit.sv
// One-bit 2:1 multiplexer built from gate primitives.
module mux21_bit (
  input  logic d0,
  input  logic d1,
  input  logic s,
  output logic y
);

  wire s_n;
  wire t0;
  wire t1;
  wire t2;
  wire y_w;

  not u_inv (s_n, s);
  and u_and0 (t0, s_n, d0);
  and u_and1 (t1, s, d1);
  // Consensus term keeps y defined when s is unknown but d0 == d1.
  and u_and2 (t2, d0, d1);
  or  u_or (y_w, t0, t1, t2);

  assign y = y_w;

endmodule

// File: rtl/mux21.sv
// WIDTH-bit 2:1 mux with a saturating select-transition counter.
// Defining MUX21_REG_OUT_EN registers Y on CLK (reset value 0).
module mux21
  import mux21_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic             S,
  output logic [WIDTH-1:0] Y,
  output logic [CNT_W-1:0] SEL_CNT
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{SAT_FILL}};

  logic [WIDTH-1:0] mux_y;
  logic             s_prev;
  logic             armed;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux21_bit u_bit (
      .d0 (D0[i]),
      .d1 (D1[i]),
      .s  (S),
      .y  (mux_y[i])
    );
  end

`ifdef MUX21_REG_OUT_EN
  logic [WIDTH-1:0] y_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) y_reg <= '0;
    else     y_reg <= mux_y;
  end

  assign Y = y_reg;
`else
  assign Y = mux_y;
`endif

  // armed stays low for the first edge after reset so that edge only captures S.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SEL_CNT <= '0;
      s_prev  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      s_prev <= S;
      armed  <= 1'b1;
      if (armed && (S != s_prev) && (SEL_CNT != CNT_MAX))
        SEL_CNT <= SEL_CNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux21.sv
// Self-checking bench for mux21 (WIDTH=4, CNT_W=8); follows MUX21_REG_OUT_EN
// when defined so the same file covers the registered-output build.
`timescale 1ns/1ps
module tb_mux21;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic [W-1:0]  D0;
  logic [W-1:0]  D1;
  logic          S;
  logic [W-1:0]  Y;
  logic [CW-1:0] SEL_CNT;

  int tests = 0;
  int fails = 0;

  bit samp[$];

  typedef struct {
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         s;
    logic [W-1:0] y;
  } vec_t;

  vec_t tbl[10];

  mux21 #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .D0      (D0),
    .D1      (D1),
    .S       (S),
    .Y       (Y),
    .SEL_CNT (SEL_CNT)
  );

  always #5 CLK = ~CLK;

  // Reference: record S at every edge since reset; count differing neighbours.
  always @(posedge CLK or posedge RST) begin
    if (RST) samp.delete();
    else     samp.push_back(S);
  end

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 1; i < samp.size(); i++)
      if (samp[i] != samp[i-1]) n++;
    return (n > 255) ? 255 : n;
  endfunction

  function automatic logic [W-1:0] ref_mux(logic [W-1:0] a, logic [W-1:0] b, logic sel);
    return sel ? b : a;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic settle();
`ifdef MUX21_REG_OUT_EN
    @(posedge CLK);
    #1;
`else
    #1;
`endif
  endtask

  initial begin
    tbl[0] = '{d0: 4'h0, d1: 4'h0, s: 1'b0, y: 4'h0};
    tbl[1] = '{d0: 4'h0, d1: 4'h0, s: 1'b1, y: 4'h0};
    tbl[2] = '{d0: 4'h0, d1: 4'hF, s: 1'b1, y: 4'hF};
    tbl[3] = '{d0: 4'h0, d1: 4'hF, s: 1'b0, y: 4'h0};
    tbl[4] = '{d0: 4'hA, d1: 4'h5, s: 1'b1, y: 4'h5};
    tbl[5] = '{d0: 4'hA, d1: 4'h5, s: 1'b0, y: 4'hA};
    tbl[6] = '{d0: 4'h3, d1: 4'hC, s: 1'b0, y: 4'h3};
    tbl[7] = '{d0: 4'h3, d1: 4'hC, s: 1'b1, y: 4'hC};
    tbl[8] = '{d0: 4'h9, d1: 4'h9, s: 1'b0, y: 4'h9};
    tbl[9] = '{d0: 4'h9, d1: 4'h9, s: 1'b1, y: 4'h9};

    RST = 1'b1; D0 = '0; D1 = '0; S = 1'b0;
    #12;
    check("reset_cnt", 32'(SEL_CNT), 32'd0);
`ifdef MUX21_REG_OUT_EN
    check("reset_y", 32'(Y), 32'd0);
`else
    D1 = 4'h6; S = 1'b1; #1;
    check("rst_no_effect_y", 32'(Y), 32'h6);
    S = 1'b0; #1;
    check("rst_no_effect_y0", 32'(Y), 32'h0);
    D1 = '0;
`endif
    @(negedge CLK);
    RST = 1'b0;

    foreach (tbl[i]) begin
      @(negedge CLK);
      D0 = tbl[i].d0; D1 = tbl[i].d1; S = tbl[i].s;
      settle();
      check($sformatf("table_%0d", i), 32'(Y), 32'(tbl[i].y));
    end

    // D0 toggles every 40 ns, D1 every 20 ns, S every 10 ns.
    for (int t = 0; t < 10; t++) begin
      logic [W-1:0] e;
      @(negedge CLK);
      D0 = ((t / 4) % 2 != 0) ? 4'hF : 4'h0;
      D1 = ((t / 2) % 2 != 0) ? 4'hF : 4'h0;
      S  = ((t % 2) != 0);
      settle();
      e = ref_mux(D0, D1, S);
      check($sformatf("wave_%0d", t), 32'(Y), 32'(e));
      if (t < 5) check($sformatf("wave_const_%0d", t), 32'(Y[0]), (t >= 3) ? 32'd1 : 32'd0);
    end

    for (int k = 0; k < 150; k++) begin
      logic [W-1:0] e;
      @(negedge CLK);
      D0 = W'($urandom); D1 = W'($urandom); S = 1'($urandom);
      e = ref_mux(D0, D1, S);
      settle();
      check("rand_y", 32'(Y), 32'(e));
    end
    @(negedge CLK);
    check("cnt_after_mux", 32'(SEL_CNT), 32'(exp_cnt()));

`ifdef MUX21_REG_OUT_EN
    D0 = 4'hA; D1 = 4'h5; S = 1'b0;
    @(posedge CLK); #1;
    check("reg_hold_a", 32'(Y), 32'hA);
    @(negedge CLK);
    S = 1'b1; #1;
    check("reg_not_yet", 32'(Y), 32'hA);
    @(posedge CLK); #1;
    check("reg_one_edge", 32'(Y), 32'h5);
`endif

    // Fresh reset; first edge must only capture S even though S differs from 0.
    @(negedge CLK);
    RST = 1'b1; #1;
    check("rst_again_cnt", 32'(SEL_CNT), 32'd0);
    @(negedge CLK);
    RST = 1'b0; S = 1'b1;
    @(negedge CLK);
    check("first_edge_nocount", 32'(SEL_CNT), 32'd0);
    @(negedge CLK);
    check("second_edge_same", 32'(SEL_CNT), 32'd0);

    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      check("toggle_cnt", 32'(SEL_CNT), 32'(exp_cnt()));
      S = ~S;
    end
    @(negedge CLK);
    check("sat_255", 32'(SEL_CNT), 32'd255);
    for (int k = 0; k < 5; k++) begin
      S = ~S;
      @(negedge CLK);
      check("sat_hold", 32'(SEL_CNT), 32'd255);
    end

    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("mid_rst_cnt", 32'(SEL_CNT), 32'd0);
`ifdef MUX21_REG_OUT_EN
    check("mid_rst_y", 32'(Y), 32'd0);
`endif
    @(negedge CLK);
    check("rst_held_cnt", 32'(SEL_CNT), 32'd0);
    RST = 1'b0;

    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      check("rand_cnt", 32'(SEL_CNT), 32'(exp_cnt()));
      S = 1'($urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
